// File: rtl/key_schedule_ctrl.sv
// key_schedule_ctrl
//   AES-128 key expansion controller. A start in IDLE loads the cipher key into
//   slot 0. Round keys 1..10 are then produced, one per clock, from the
//   previous slot using a single shared 4-byte S-box. All 11 round keys stay in
//   storage for random-access readout.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      expand key_in (accepted only while idle)
//   key_in     128-bit cipher key, w0 in [127:96], FIPS-197 byte order
//   rd_idx     round-key select, 0..10 (11..15 read as zero)
//   rd_key     combinational readout of slot rd_idx
//   busy       expansion in progress
//   done       one-cycle pulse after round key 10 is stored
//   keys_valid all stored round keys belong to the last accepted key
module key_schedule_ctrl (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [127:0] key_in,
   input  logic [3:0]   rd_idx,
   output logic [127:0] rd_key,
   output logic         busy,
   output logic         done,
   output logic         keys_valid
);

   typedef enum logic {StIdle, StExpand} state_e;

   state_e       state_q, state_d;
   logic [127:0] keys_q [0:10];
   logic [3:0]   round_q;
   logic [7:0]   rcon_q;
   logic         busy_q, done_q, valid_q;

   logic         accept, step, last;
   logic [3:0]   prev_idx;
   logic [127:0] prev_key, next_key;
   logic [31:0]  rot_word, sub_word, t_word;
   logic [31:0]  w0n, w1n, w2n, w3n;
   logic [7:0]   rcon_next;

   // GF(2^8) multiply, reduction polynomial x^8+x^4+x^3+x+1.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // S-box: multiplicative inverse as b^254 (0 maps to 0), then the affine map.
   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [7:0] inv;
      logic [7:0] sq;
      inv = 8'h01;
      sq  = b;
      for (int i = 0; i < 7; i++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                 ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   // FSM next state
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      step    = 1'b0;
      last    = 1'b0;
      case (state_q)
         StIdle: begin
            if (start) begin
               accept  = 1'b1;
               state_d = StExpand;
            end
         end
         StExpand: begin
            step = 1'b1;
            if (round_q == 4'd10) begin
               last    = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   // Round function on slot round-1; the only S-box use in the design.
   always_comb begin
      prev_idx = round_q - 4'd1;
      prev_key = '0;
      if (prev_idx <= 4'd10) prev_key = keys_q[prev_idx];
      rot_word = {prev_key[23:0], prev_key[31:24]};
      sub_word = {sbox(rot_word[31:24]), sbox(rot_word[23:16]),
                  sbox(rot_word[15:8]),  sbox(rot_word[7:0])};
      t_word   = sub_word ^ {rcon_q, 24'h0};
      w0n      = prev_key[127:96] ^ t_word;
      w1n      = prev_key[95:64]  ^ w0n;
      w2n      = prev_key[63:32]  ^ w1n;
      w3n      = prev_key[31:0]   ^ w2n;
      next_key = {w0n, w1n, w2n, w3n};
      rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i <= 10; i++) keys_q[i] <= '0;
         round_q <= 4'd0;
         rcon_q  <= 8'h01;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         done_q <= last;
         if (accept) begin
            keys_q[0] <= key_in;
            rcon_q    <= 8'h01;
            round_q   <= 4'd1;
            busy_q    <= 1'b1;
            valid_q   <= 1'b0;
         end else if (step) begin
            keys_q[round_q] <= next_key;
            rcon_q          <= rcon_next;
            if (last) begin
               busy_q  <= 1'b0;
               valid_q <= 1'b1;
            end else begin
               round_q <= round_q + 4'd1;
            end
         end
      end
   end

   always_comb begin
      rd_key = '0;
      if (rd_idx <= 4'd10) rd_key = keys_q[rd_idx];
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign keys_valid = valid_q;

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Self-checking bench for key_schedule_ctrl: FIPS-197 and all-zero vectors,
// random keys against a word-array key-expansion model, start-while-busy,
// reset mid-expansion and back-to-back restart.
module tb_key_schedule_ctrl;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [127:0] key_in;
   logic [3:0]   rd_idx;
   logic [127:0] rd_key;
   logic         busy;
   logic         done;
   logic         keys_valid;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0]   sbox_tab [0:255];
   logic [127:0] model_rk [0:10];
   logic [7:0]   rcon_tab [0:10];

   key_schedule_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .key_in     (key_in),
      .rd_idx     (rd_idx),
      .rd_key     (rd_key),
      .busy       (busy),
      .done       (done),
      .keys_valid (keys_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      logic [7:0] bb;
      p  = 8'h00;
      aa = a;
      bb = b;
      while (bb != 8'h00) begin
         if (bb[0]) p = p ^ aa;
         aa = (aa[7]) ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
         bb = bb >> 1;
      end
      return p;
   endfunction

   // S-box table: inverse by exhaustive search, affine map bitwise.
   task automatic build_sbox();
      logic [7:0] inv;
      logic [7:0] s;
      logic [7:0] c;
      c = 8'h63;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (ref_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8]
                   ^ inv[(i + 7) % 8] ^ c[i];
         sbox_tab[x] = s;
      end
      rcon_tab = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                   8'h1b, 8'h36};
   endtask

   task automatic model_expand(input logic [127:0] key);
      logic [31:0] w [0:43];
      logic [31:0] tmp;
      w[0] = key[127:96];
      w[1] = key[95:64];
      w[2] = key[63:32];
      w[3] = key[31:0];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i - 1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {sbox_tab[tmp[31:24]], sbox_tab[tmp[23:16]], sbox_tab[tmp[15:8]],
                   sbox_tab[tmp[7:0]]};
            tmp = tmp ^ {rcon_tab[i / 4], 24'h0};
         end
         w[i] = w[i - 4] ^ tmp;
      end
      for (int r = 0; r <= 10; r++)
         model_rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
   endtask

   task automatic check_all_keys(input string tag);
      for (int i = 0; i <= 10; i++) begin
         rd_idx = 4'(i);
         #1;
         check(tag, rd_key, model_rk[i]);
      end
      rd_idx = 4'($urandom_range(15, 11));
      #1;
      check({tag, "_oob"}, rd_key, 128'h0);
   endtask

   // Accept on the next edge, then follow the expansion cycle by cycle.
   task automatic run_expand(input logic [127:0] key, input bit disturb);
      int dones;
      model_expand(key);
      start  = 1'b1;
      key_in = key;
      tick();
      start  = 1'b0;
      key_in = rand128();
      check("acc_busy", 128'(busy), 128'(1));
      check("acc_valid", 128'(keys_valid), 128'(0));
      rd_idx = 4'd0;
      #1;
      check("acc_slot0", rd_key, key);
      dones = 0;
      for (int k = 1; k <= 10; k++) begin
         start  = (disturb && (k == 3 || k == 7)) ? 1'b1 : 1'b0;
         key_in = rand128();
         tick();
         if (done) dones++;
         check("exp_busy", 128'(busy), 128'(k < 10));
         check("exp_done", 128'(done), 128'(k == 10));
         check("exp_valid", 128'(keys_valid), 128'(k == 10));
         rd_idx = 4'(k);
         #1;
         check("exp_slot", rd_key, model_rk[k]);
      end
      start = 1'b0;
      tick();
      check("post_done", 128'(done), 128'(0));
      check("post_busy", 128'(busy), 128'(0));
      check("done_count", 128'(dones), 128'(1));
      check_all_keys("keys");
   endtask

   initial begin
      logic [127:0] ka;
      logic [127:0] kb;
      rst_n  = 1'b0;
      start  = 1'b0;
      key_in = '0;
      rd_idx = '0;
      build_sbox();
      #2;
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_done", 128'(done), 128'(0));
      check("rst_valid", 128'(keys_valid), 128'(0));
      for (int i = 0; i < 16; i++) begin
         rd_idx = 4'(i);
         #1;
         check("rst_slot", rd_key, 128'h0);
      end

      // First start right after reset release, FIPS-197 vector.
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      run_expand(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0);
      rd_idx = 4'd1;
      #1;
      check("fips_rk1", rd_key, 128'ha0fafe1788542cb123a339392a6c7605);
      rd_idx = 4'd10;
      #1;
      check("fips_rk10", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      rd_idx = 4'd0;
      #1;
      check("fips_rk0", rd_key, 128'h2b7e151628aed2a6abf7158809cf4f3c);

      // All-zero key.
      run_expand(128'h0, 1'b0);
      rd_idx = 4'd1;
      #1;
      check("zero_rk1", rd_key, 128'h62636363626363636263636362636363);
      rd_idx = 4'd10;
      #1;
      check("zero_rk10", rd_key, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

      // Random keys, some with start pulses while busy.
      for (int n = 0; n < 6; n++) run_expand(rand128(), n[0]);

      // Reset mid-expansion.
      start  = 1'b1;
      key_in = rand128();
      tick();
      start = 1'b0;
      for (int k = 1; k <= 5; k++) tick();
      rst_n = 1'b0;
      #1;
      check("mrst_busy", 128'(busy), 128'(0));
      check("mrst_done", 128'(done), 128'(0));
      check("mrst_valid", 128'(keys_valid), 128'(0));
      for (int i = 0; i < 16; i++) begin
         rd_idx = 4'(i);
         #1;
         check("mrst_slot", rd_key, 128'h0);
      end
      for (int k = 0; k < 8; k++) begin
         tick();
         check("mrst_nodone", 128'(done), 128'(0));
      end
      rst_n = 1'b1;
      run_expand(rand128(), 1'b1);

      // Back-to-back: start held across the done cycle.
      ka = rand128();
      kb = rand128();
      model_expand(ka);
      start  = 1'b1;
      key_in = ka;
      tick();
      key_in = kb;
      for (int k = 1; k <= 10; k++) begin
         tick();
         check("b2b_done1", 128'(done), 128'(k == 10));
         check("b2b_valid1", 128'(keys_valid), 128'(k == 10));
         rd_idx = 4'd12;
         #1;
         check("b2b_idx12", rd_key, 128'h0);
         if (k == 10) begin
            rd_idx = 4'd10;
            #1;
            check("b2b_rk10a", rd_key, model_rk[10]);
         end
      end
      model_expand(kb);
      tick();
      key_in = rand128();
      check("b2b_restart_busy", 128'(busy), 128'(1));
      check("b2b_restart_valid", 128'(keys_valid), 128'(0));
      check("b2b_restart_done", 128'(done), 128'(0));
      rd_idx = 4'd0;
      #1;
      check("b2b_slot0", rd_key, kb);
      for (int k = 1; k <= 10; k++) begin
         tick();
         check("b2b_done2", 128'(done), 128'(k == 10));
         check("b2b_valid2", 128'(keys_valid), 128'(k == 10));
         rd_idx = 4'd12;
         #1;
         check("b2b_idx12", rd_key, 128'h0);
         if (k == 10) start = 1'b0;
      end
      tick();
      check("b2b_idle", 128'(busy), 128'(0));
      check_all_keys("b2b_keys");

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule

// File: doc/key_schedule_ctrl.md
KEY_SCHEDULE_CTRL -- requirements
Module: key_schedule_ctrl

Interface
REQ-001 The block SHALL have no parameters; AES-128 with 10 rounds is fixed.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset, with ports clk and rst_n.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request to expand key_in; sampled on the rising edge of clk.
REQ-006 key_in  input  128  cipher key; bits [127:96] are word w0 and byte 0 is the MSB (FIPS-197 order).
REQ-007 rd_idx  input  4  round-key select, 0..10.
REQ-008 rd_key  output  128  round key rd_idx, combinational from storage, same word order as key_in.
REQ-009 busy  output  1  expansion in progress.
REQ-010 done  output  1  one-cycle pulse when round key 10 is stored.
REQ-011 keys_valid  output  1  all 11 stored round keys belong to the last accepted key.

Function
REQ-012 The FSM SHALL have exactly two states, IDLE and EXPAND; there is no separate DONE state.
REQ-013 In IDLE, start=1 SHALL be accepted on the edge; at that edge:
  - key slot 0 <= key_in;
  - rcon <= 8'h01;
  - round counter <= 1;
  - state <= EXPAND;
  - busy <= 1;
  - keys_valid <= 0.
REQ-014 In EXPAND, each edge SHALL compute and store exactly one round key r into slot r, from slot r-1:
  - t = SubWord(RotWord(w3)) ^ {rcon, 24'h0}, where RotWord({a0,a1,a2,a3}) = {a1,a2,a3,a0};
  - w0' = w0 ^ t;
  - w1' = w1 ^ w0';
  - w2' = w2 ^ w1';
  - w3' = w3 ^ w2'.
REQ-015 SubWord SHALL use exactly one 4-byte S-box instance, shared across all rounds.
REQ-016 rcon SHALL advance by GF(2^8) xtime after each round: shift left 1; XOR 8'h1B if the shifted-out bit was 1 (sequence 01,02,04,08,10,20,40,80,1B,36).
REQ-017 On the edge that stores round 10:
  - state <= IDLE;
  - busy <= 0;
  - keys_valid <= 1;
  - done <= 1 for exactly one cycle.
REQ-018 Latency SHALL be fixed: done is high in the 10th cycle after the start-accept edge, and busy is high for exactly 10 cycles.
REQ-019 start asserted while busy=1 SHALL be ignored, with no queuing and no effect on the running expansion.
REQ-020 start asserted in the cycle done=1 (state IDLE) SHALL be accepted normally and clear keys_valid at that edge.
REQ-021 Holding start=1 continuously SHALL restart expansion every 11 cycles.
REQ-022 rd_key SHALL return the current contents of slot rd_idx for rd_idx 0..10, including partially updated slots while busy; rd_idx 11..15 SHALL return 128'h0.
REQ-023 key_in SHALL be sampled only on the start-accept edge; later changes to key_in SHALL have no effect.
REQ-024 The round counter SHALL be 4 bits and SHALL never exceed 10.

Reset
REQ-025 While rst_n=0 (asynchronously):
  - state = IDLE;
  - busy = 0;
  - done = 0;
  - keys_valid = 0;
  - round counter = 0;
  - rcon = 8'h01;
  - all 11 key slots = 128'h0.
REQ-026 Reset asserted mid-expansion SHALL abort the expansion with no done pulse; after release the block SHALL be idle and accept a new start.
REQ-027 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-028 FIPS-197 vector. Stimulus: start with key_in = 2b7e151628aed2a6abf7158809cf4f3c. Required response:
  - done 10 cycles later;
  - rd_idx=1 -> a0fafe1788542cb123a339392a6c7605;
  - rd_idx=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6;
  - rd_idx=0 -> the input key.
REQ-029 All-zero key. Stimulus: start with key_in = 0. Required response:
  - rd_idx=1 -> 62636363626363636263636362636363;
  - rd_idx=10 -> b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-030 Start while busy. Stimulus: start pulsed at cycles 3 and 7 of a running expansion with a different key_in. Required response:
  - done timing unchanged;
  - keys match the first key.
REQ-031 Reset mid-expansion. Stimulus: rst_n low at cycle 5 of expansion. Required response:
  - busy=0, done never pulses, keys_valid=0, every rd_idx reads 0;
  - a subsequent start completes correctly.
REQ-032 Back-to-back restart. Stimulus: start held high across the done cycle. Required response:
  - second expansion begins on the done edge;
  - keys_valid drops for 10 cycles and then rises again;
  - rd_idx=12 -> 0 at all times.
